// File: rtl/decode_dispatch.sv
// Decode-and-dispatch stage: buffers fetched RV32I instructions, decodes the
// queue head, resolves its operands and issues at most one per cycle to RS/LSB.
module decode_dispatch #(
    parameter int IQ_DEPTH = 4,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_pc,
    input  logic             if_pred_taken,
    output logic             iq_full,
    input  logic             rob_full,
    input  logic             rs_full,
    input  logic             lsb_full,
    input  logic [TAG_W-1:0] rob_tail,
    output logic [4:0]       reg_rs1,
    output logic [4:0]       reg_rs2,
    input  logic             reg_rs1_busy,
    input  logic             reg_rs2_busy,
    input  logic [31:0]      reg_rs1_val,
    input  logic [31:0]      reg_rs2_val,
    input  logic [TAG_W-1:0] reg_rs1_tag,
    input  logic [TAG_W-1:0] reg_rs2_tag,
    output logic [TAG_W-1:0] rob_q1,
    output logic [TAG_W-1:0] rob_q2,
    input  logic             rob_q1_ready,
    input  logic             rob_q2_ready,
    input  logic [31:0]      rob_q1_val,
    input  logic [31:0]      rob_q2_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
    output logic             dsp_valid,
    output logic             dsp_to_rs,
    output logic             dsp_to_lsb,
    output logic [5:0]       dsp_op,
    output logic [4:0]       dsp_rd,
    output logic [TAG_W-1:0] dsp_tag,
    output logic [31:0]      dsp_imm,
    output logic [31:0]      dsp_pc,
    output logic             dsp_pred_taken,
    output logic             dsp_rs1_ready,
    output logic             dsp_rs2_ready,
    output logic [31:0]      dsp_rs1_val,
    output logic [31:0]      dsp_rs2_val,
    output logic [TAG_W-1:0] dsp_rs1_tag,
    output logic [TAG_W-1:0] dsp_rs2_tag
);
    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = $clog2(IQ_DEPTH + 1);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OPIMM  = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [5:0] {
        OP_NONE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    typedef struct packed {
        logic             ready;
        logic [31:0]      val;
        logic [TAG_W-1:0] tag;
    } opnd_t;

    logic [31:0]      q_instr [IQ_DEPTH];
    logic [31:0]      q_pc    [IQ_DEPTH];
    logic             q_pred  [IQ_DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic [31:0] h_instr;
    logic [2:0]  funct3;
    logic        legal, to_rs, to_lsb, use1, use2, has_rd;
    logic [31:0] imm;
    op_e         op;
    opnd_t       src1, src2;
    logic        push, pop, dsp_go;

    assign h_instr = q_instr[head];
    assign funct3  = h_instr[14:12];
    assign iq_full = (count == CNT_W'(IQ_DEPTH));
    assign reg_rs1 = h_instr[19:15];
    assign reg_rs2 = h_instr[24:20];
    assign rob_q1  = reg_rs1_tag;
    assign rob_q2  = reg_rs2_tag;

    always_comb begin
        legal  = 1'b1;
        to_rs  = 1'b1;
        to_lsb = 1'b0;
        use1   = 1'b0;
        use2   = 1'b0;
        has_rd = 1'b1;
        imm    = '0;
        op     = OP_NONE;
        case (h_instr[6:0])
            OPC_LUI: begin
                op  = OP_LUI;
                imm = {h_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                op  = OP_AUIPC;
                imm = {h_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                op  = OP_JAL;
                imm = {{12{h_instr[31]}}, h_instr[19:12], h_instr[20], h_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                op   = OP_JALR;
                use1 = 1'b1;
                imm  = {{20{h_instr[31]}}, h_instr[31:20]};
            end
            OPC_BRANCH: begin
                use1   = 1'b1;
                use2   = 1'b1;
                has_rd = 1'b0;
                imm    = {{20{h_instr[31]}}, h_instr[7], h_instr[30:25], h_instr[11:8], 1'b0};
                case (funct3)
                    3'd0:    op = OP_BEQ;
                    3'd1:    op = OP_BNE;
                    3'd4:    op = OP_BLT;
                    3'd5:    op = OP_BGE;
                    3'd6:    op = OP_BLTU;
                    3'd7:    op = OP_BGEU;
                    default: op = OP_NONE;
                endcase
            end
            OPC_LOAD: begin
                to_rs  = 1'b0;
                to_lsb = 1'b1;
                use1   = 1'b1;
                imm    = {{20{h_instr[31]}}, h_instr[31:20]};
                case (funct3)
                    3'd0:    op = OP_LB;
                    3'd1:    op = OP_LH;
                    3'd2:    op = OP_LW;
                    3'd4:    op = OP_LBU;
                    3'd5:    op = OP_LHU;
                    default: op = OP_NONE;
                endcase
            end
            OPC_STORE: begin
                to_rs  = 1'b0;
                to_lsb = 1'b1;
                use1   = 1'b1;
                use2   = 1'b1;
                has_rd = 1'b0;
                imm    = {{20{h_instr[31]}}, h_instr[31:25], h_instr[11:7]};
                case (funct3)
                    3'd0:    op = OP_SB;
                    3'd1:    op = OP_SH;
                    3'd2:    op = OP_SW;
                    default: op = OP_NONE;
                endcase
            end
            OPC_OPIMM: begin
                use1 = 1'b1;
                // shifts carry a 5-bit unsigned shamt instead of a signed immediate
                if (funct3 == 3'd1 || funct3 == 3'd5)
                    imm = {27'b0, h_instr[24:20]};
                else
                    imm = {{20{h_instr[31]}}, h_instr[31:20]};
                case (funct3)
                    3'd0: op = OP_ADDI;
                    3'd1: op = OP_SLLI;
                    3'd2: op = OP_SLTI;
                    3'd3: op = OP_SLTIU;
                    3'd4: op = OP_XORI;
                    3'd5: op = h_instr[30] ? OP_SRAI : OP_SRLI;
                    3'd6: op = OP_ORI;
                    3'd7: op = OP_ANDI;
                    default: op = OP_NONE;
                endcase
            end
            OPC_OP: begin
                use1 = 1'b1;
                use2 = 1'b1;
                case (funct3)
                    3'd0: op = h_instr[30] ? OP_SUB : OP_ADD;
                    3'd1: op = OP_SLL;
                    3'd2: op = OP_SLT;
                    3'd3: op = OP_SLTU;
                    3'd4: op = OP_XOR;
                    3'd5: op = h_instr[30] ? OP_SRA : OP_SRL;
                    3'd6: op = OP_OR;
                    3'd7: op = OP_AND;
                    default: op = OP_NONE;
                endcase
            end
            default: begin
                legal  = 1'b0;
                to_rs  = 1'b0;
                has_rd = 1'b0;
            end
        endcase
    end

    // The previous dispatch is not yet visible in the register file, so it
    // takes precedence over the rename state for a matching destination.
    function automatic opnd_t resolve(
        input logic             used,
        input logic [4:0]       addr,
        input logic             busy,
        input logic [31:0]      rf_val,
        input logic [TAG_W-1:0] rf_tag,
        input logic             rob_rdy,
        input logic [31:0]      rob_val,
        input logic             fwd_valid,
        input logic [4:0]       fwd_rd,
        input logic [TAG_W-1:0] fwd_tag,
        input logic             cv,
        input logic [TAG_W-1:0] ct,
        input logic [31:0]      cd
    );
        opnd_t r;
        r.ready = 1'b1;
        r.val   = '0;
        r.tag   = '0;
        if (used && addr != 5'd0) begin
            if (fwd_valid && fwd_rd == addr) begin
                if (cv && ct == fwd_tag) begin
                    r.val = cd;
                end else begin
                    r.ready = 1'b0;
                    r.tag   = fwd_tag;
                end
            end else if (!busy) begin
                r.val = rf_val;
            end else if (rob_rdy) begin
                r.val = rob_val;
            end else if (cv && ct == rf_tag) begin
                r.val = cd;
            end else begin
                r.ready = 1'b0;
                r.tag   = rf_tag;
            end
        end
        return r;
    endfunction

    always_comb begin
        src1 = resolve(use1, reg_rs1, reg_rs1_busy, reg_rs1_val, reg_rs1_tag, rob_q1_ready,
                       rob_q1_val, dsp_valid, dsp_rd, dsp_tag, cdb_valid, cdb_tag, cdb_val);
        src2 = resolve(use2, reg_rs2, reg_rs2_busy, reg_rs2_val, reg_rs2_tag, rob_q2_ready,
                       rob_q2_val, dsp_valid, dsp_rd, dsp_tag, cdb_valid, cdb_tag, cdb_val);
    end

    assign dsp_go = rdy & ~flush & (count != '0) & legal & ~rob_full &
                    (to_rs ? ~rs_full : ~lsb_full);
    assign pop    = dsp_go | (rdy & ~flush & (count != '0) & ~legal);
    assign push   = if_valid & ~iq_full & rdy & ~flush;

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= if_instr;
            q_pc[tail]    <= if_pc;
            q_pred[tail]  <= if_pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            dsp_valid      <= 1'b0;
            dsp_to_rs      <= 1'b0;
            dsp_to_lsb     <= 1'b0;
            dsp_op         <= '0;
            dsp_rd         <= '0;
            dsp_tag        <= '0;
            dsp_imm        <= '0;
            dsp_pc         <= '0;
            dsp_pred_taken <= 1'b0;
            dsp_rs1_ready  <= 1'b0;
            dsp_rs2_ready  <= 1'b0;
            dsp_rs1_val    <= '0;
            dsp_rs2_val    <= '0;
            dsp_rs1_tag    <= '0;
            dsp_rs2_tag    <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            dsp_valid <= 1'b0;
        end else if (rdy) begin
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            dsp_valid <= dsp_go;
            if (dsp_go) begin
                dsp_to_rs      <= to_rs;
                dsp_to_lsb     <= to_lsb;
                dsp_op         <= op;
                dsp_rd         <= has_rd ? h_instr[11:7] : 5'd0;
                dsp_tag        <= rob_tail;
                dsp_imm        <= imm;
                dsp_pc         <= q_pc[head];
                dsp_pred_taken <= q_pred[head];
                dsp_rs1_ready  <= src1.ready;
                dsp_rs2_ready  <= src2.ready;
                dsp_rs1_val    <= src1.val;
                dsp_rs2_val    <= src2.val;
                dsp_rs1_tag    <= src1.tag;
                dsp_rs2_tag    <= src2.tag;
            end
        end
    end

endmodule

// File: tb/tb_decode_dispatch.sv
// Scoreboard bench for decode_dispatch: a queue-based reference model predicts
// every edge; a negedge monitor compares the DUT against the predictions.
module tb_decode_dispatch;
    localparam int DEPTH = 4;
    localparam int TW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rdy, flush, if_valid, if_pred_taken, iq_full;
    logic [31:0]   if_instr, if_pc;
    logic          rob_full, rs_full, lsb_full;
    logic [TW-1:0] rob_tail;
    logic [4:0]    reg_rs1, reg_rs2;
    logic          reg_rs1_busy, reg_rs2_busy;
    logic [31:0]   reg_rs1_val, reg_rs2_val;
    logic [TW-1:0] reg_rs1_tag, reg_rs2_tag, rob_q1, rob_q2;
    logic          rob_q1_ready, rob_q2_ready;
    logic [31:0]   rob_q1_val, rob_q2_val;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_val;
    logic          dsp_valid, dsp_to_rs, dsp_to_lsb, dsp_pred_taken;
    logic [5:0]    dsp_op;
    logic [4:0]    dsp_rd;
    logic [TW-1:0] dsp_tag, dsp_rs1_tag, dsp_rs2_tag;
    logic [31:0]   dsp_imm, dsp_pc, dsp_rs1_val, dsp_rs2_val;
    logic          dsp_rs1_ready, dsp_rs2_ready;

    decode_dispatch #(.IQ_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .iq_full(iq_full), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_tail(rob_tail), .reg_rs1(reg_rs1), .reg_rs2(reg_rs2),
        .reg_rs1_busy(reg_rs1_busy), .reg_rs2_busy(reg_rs2_busy),
        .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val),
        .reg_rs1_tag(reg_rs1_tag), .reg_rs2_tag(reg_rs2_tag),
        .rob_q1(rob_q1), .rob_q2(rob_q2), .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
        .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .dsp_valid(dsp_valid), .dsp_to_rs(dsp_to_rs), .dsp_to_lsb(dsp_to_lsb), .dsp_op(dsp_op),
        .dsp_rd(dsp_rd), .dsp_tag(dsp_tag), .dsp_imm(dsp_imm), .dsp_pc(dsp_pc),
        .dsp_pred_taken(dsp_pred_taken), .dsp_rs1_ready(dsp_rs1_ready), .dsp_rs2_ready(dsp_rs2_ready),
        .dsp_rs1_val(dsp_rs1_val), .dsp_rs2_val(dsp_rs2_val),
        .dsp_rs1_tag(dsp_rs1_tag), .dsp_rs2_tag(dsp_rs2_tag)
    );

    // Register-file and ROB stand-ins answer whatever address the DUT presents.
    logic          rf_busy  [32];
    logic [31:0]   rf_val   [32];
    logic [TW-1:0] rf_tag   [32];
    logic          rob_rdy  [1<<TW];
    logic [31:0]   rob_vals [1<<TW];

    assign reg_rs1_busy = rf_busy[reg_rs1];
    assign reg_rs2_busy = rf_busy[reg_rs2];
    assign reg_rs1_val  = rf_val[reg_rs1];
    assign reg_rs2_val  = rf_val[reg_rs2];
    assign reg_rs1_tag  = rf_tag[reg_rs1];
    assign reg_rs2_tag  = rf_tag[reg_rs2];
    assign rob_q1_ready = rob_rdy[rob_q1];
    assign rob_q2_ready = rob_rdy[rob_q2];
    assign rob_q1_val   = rob_vals[rob_q1];
    assign rob_q2_val   = rob_vals[rob_q2];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    typedef struct {
        logic        legal, to_rs, to_lsb, use1, use2;
        logic [4:0]  rd;
        logic [5:0]  op;
        logic [31:0] imm;
    } dec_t;

    typedef struct {
        int            k;
        logic          to_rs, to_lsb, pred, r1, r2;
        logic [5:0]    op;
        logic [4:0]    rd;
        logic [TW-1:0] tag, t1, t2;
        logic [31:0]   imm, pc, v1, v2;
    } exp_t;

    ent_t          mq[$];
    exp_t          sb[$];
    exp_t          last;
    bit            exp_full_a [int];
    logic          pv;
    logic [4:0]    prd;
    logic [TW-1:0] ptag;
    int            cyc = 0;
    bit            run = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   pc_ctr = 32'h1000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic dec_t decode(input logic [31:0] i);
        dec_t        d;
        logic [2:0]  f3;
        logic [11:0] i12, s12;
        logic [12:0] b13;
        logic [20:0] j21;
        f3  = i[14:12];
        i12 = i[31:20];
        s12 = {i[31:25], i[11:7]};
        b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        d.legal = 1; d.to_rs = 1; d.to_lsb = 0; d.use1 = 0; d.use2 = 0;
        d.rd = i[11:7]; d.op = 0; d.imm = 0;
        case (i[6:0])
            7'h37: begin d.op = 1; d.imm = {i[31:12], 12'h000}; end
            7'h17: begin d.op = 2; d.imm = {i[31:12], 12'h000}; end
            7'h6f: begin d.op = 3; d.imm = 32'($signed(j21)); end
            7'h67: begin d.op = 4; d.use1 = 1; d.imm = 32'($signed(i12)); end
            7'h63: begin
                d.use1 = 1; d.use2 = 1; d.rd = 0; d.imm = 32'($signed(b13));
                case (f3)
                    3'd0: d.op = 5;  3'd1: d.op = 6;  3'd4: d.op = 7;
                    3'd5: d.op = 8;  3'd6: d.op = 9;  3'd7: d.op = 10;
                    default: d.op = 0;
                endcase
            end
            7'h03: begin
                d.to_rs = 0; d.to_lsb = 1; d.use1 = 1; d.imm = 32'($signed(i12));
                case (f3)
                    3'd0: d.op = 11; 3'd1: d.op = 12; 3'd2: d.op = 13;
                    3'd4: d.op = 14; 3'd5: d.op = 15;
                    default: d.op = 0;
                endcase
            end
            7'h23: begin
                d.to_rs = 0; d.to_lsb = 1; d.use1 = 1; d.use2 = 1; d.rd = 0;
                d.imm = 32'($signed(s12));
                d.op = (f3 < 3) ? 6'(16 + f3) : 6'd0;
            end
            7'h13: begin
                d.use1 = 1;
                d.imm = (f3 == 1 || f3 == 5) ? 32'(i[24:20]) : 32'($signed(i12));
                case (f3)
                    3'd0: d.op = 19; 3'd1: d.op = 25; 3'd2: d.op = 20; 3'd3: d.op = 21;
                    3'd4: d.op = 22; 3'd5: d.op = i[30] ? 6'd27 : 6'd26;
                    3'd6: d.op = 23; default: d.op = 24;
                endcase
            end
            7'h33: begin
                d.use1 = 1; d.use2 = 1;
                case (f3)
                    3'd0: d.op = i[30] ? 6'd29 : 6'd28;
                    3'd1: d.op = 30; 3'd2: d.op = 31; 3'd3: d.op = 32; 3'd4: d.op = 33;
                    3'd5: d.op = i[30] ? 6'd35 : 6'd34;
                    3'd6: d.op = 36; default: d.op = 37;
                endcase
            end
            default: begin d.legal = 0; d.to_rs = 0; d.rd = 0; end
        endcase
        return d;
    endfunction

    function automatic void resolve(input logic used, input logic [4:0] a, output logic r,
                                    output logic [31:0] v, output logic [TW-1:0] t);
        r = 1; v = 0; t = 0;
        if (!used || a == 0) return;
        if (pv && prd == a) begin
            if (cdb_valid && cdb_tag == ptag) v = cdb_val;
            else begin r = 0; t = ptag; end
            return;
        end
        if (!rf_busy[a]) v = rf_val[a];
        else if (rob_rdy[rf_tag[a]]) v = rob_vals[rf_tag[a]];
        else if (cdb_valid && cdb_tag == rf_tag[a]) v = cdb_val;
        else begin r = 0; t = rf_tag[a]; end
    endfunction

    // Predicts the outcome of the coming clock edge from the inputs now driven.
    task automatic model_step();
        int   k;
        dec_t d;
        exp_t e;
        ent_t ne;
        logic full_before, disp;
        k = cyc + 1;
        if (flush) begin
            mq.delete();
            pv = 0;
        end else if (!rdy) begin
            if (pv) begin e = last; e.k = k; sb.push_back(e); end
        end else begin
            full_before = (mq.size() == DEPTH);
            disp = 0;
            if (mq.size() != 0) begin
                d = decode(mq[0].instr);
                if (!d.legal) begin
                    void'(mq.pop_front());
                end else if (!rob_full && (d.to_rs ? !rs_full : !lsb_full)) begin
                    e.k = k; e.to_rs = d.to_rs; e.to_lsb = d.to_lsb; e.op = d.op;
                    e.rd = d.rd; e.tag = rob_tail; e.imm = d.imm;
                    e.pc = mq[0].pc; e.pred = mq[0].pred;
                    resolve(d.use1, mq[0].instr[19:15], e.r1, e.v1, e.t1);
                    resolve(d.use2, mq[0].instr[24:20], e.r2, e.v2, e.t2);
                    sb.push_back(e);
                    last = e;
                    void'(mq.pop_front());
                    disp = 1;
                end
            end
            if (if_valid && !full_before) begin
                ne.instr = if_instr; ne.pc = if_pc; ne.pred = if_pred_taken;
                mq.push_back(ne);
            end
            if (disp) begin prd = e.rd; ptag = e.tag; end
            pv = disp;
        end
        exp_full_a[k] = (mq.size() == DEPTH);
    endtask

    always @(posedge clk) begin
        #2;
        if (run) model_step();
    end

    exp_t me;
    logic mev;
    always @(negedge clk) begin
        if (exp_full_a.exists(cyc)) begin
            mev = (sb.size() > 0) && (sb[0].k == cyc);
            chk("iq_full", 32'(iq_full), 32'(exp_full_a[cyc]));
            chk("dsp_valid", 32'(dsp_valid), 32'(mev));
            if (mev) begin
                me = sb.pop_front();
                if (dsp_valid) begin
                    chk("dsp_to_rs", 32'(dsp_to_rs), 32'(me.to_rs));
                    chk("dsp_to_lsb", 32'(dsp_to_lsb), 32'(me.to_lsb));
                    chk("dsp_op", 32'(dsp_op), 32'(me.op));
                    chk("dsp_rd", 32'(dsp_rd), 32'(me.rd));
                    chk("dsp_tag", 32'(dsp_tag), 32'(me.tag));
                    chk("dsp_imm", dsp_imm, me.imm);
                    chk("dsp_pc", dsp_pc, me.pc);
                    chk("dsp_pred", 32'(dsp_pred_taken), 32'(me.pred));
                    chk("rs1_ready", 32'(dsp_rs1_ready), 32'(me.r1));
                    if (me.r1) chk("rs1_val", dsp_rs1_val, me.v1);
                    else       chk("rs1_tag", 32'(dsp_rs1_tag), 32'(me.t1));
                    chk("rs2_ready", 32'(dsp_rs2_ready), 32'(me.r2));
                    if (me.r2) chk("rs2_val", dsp_rs2_val, me.v2);
                    else       chk("rs2_tag", 32'(dsp_rs2_tag), 32'(me.t2));
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] ins);
        if_valid      = v;
        if_instr      = ins;
        if_pc         = pc_ctr;
        if_pred_taken = 1'($urandom);
        pc_ctr        = pc_ctr + 4;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [31:0] rnd;
        rnd = $urandom;
        rd  = 5'($urandom_range(0, 7));
        r1  = 5'($urandom_range(0, 7));
        r2  = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0: return {rnd[31:12], rd, 7'h37};
            1: return {rnd[31:12], rd, 7'h17};
            2: return {rnd[31:12], rd, 7'h6f};
            3: return {rnd[31:20], r1, 3'b000, rd, 7'h67};
            4: begin
                if (f3 == 2 || f3 == 3) f3 = 0;
                return {rnd[31:25], r2, r1, f3, rnd[11:7], 7'h63};
            end
            5: begin
                if (f3 == 3 || f3 > 5) f3 = 2;
                return {rnd[31:20], r1, f3, rd, 7'h03};
            end
            6: begin
                f3 = 3'($urandom_range(0, 2));
                return {rnd[31:25], r2, r1, f3, rnd[11:7], 7'h23};
            end
            7: begin
                if (f3 == 1) return {7'b0, rnd[24:20], r1, f3, rd, 7'h13};
                if (f3 == 5) return {1'b0, rnd[30], 5'b0, rnd[24:20], r1, f3, rd, 7'h13};
                return {rnd[31:20], r1, f3, rd, 7'h13};
            end
            8: return {1'b0, (f3 == 0 || f3 == 5) ? rnd[30] : 1'b0, 5'b0, r2, r1, f3, rd, 7'h33};
            default: return {rnd[31:7], rnd[0] ? 7'h0f : 7'h73};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_busy[i] = 0; rf_val[i] = $urandom; rf_tag[i] = TW'($urandom);
        end
        for (int i = 0; i < (1 << TW); i++) begin
            rob_rdy[i] = 0; rob_vals[i] = $urandom;
        end
        rst = 1; rdy = 1; flush = 0; if_valid = 0; if_instr = 0; if_pc = 0; if_pred_taken = 0;
        rob_full = 0; rs_full = 0; lsb_full = 0; rob_tail = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_val = 0;
        pv = 0; prd = 0; ptag = 0;
        repeat (3) @(posedge clk);
        #4;
        chk("reset_dsp_valid", 32'(dsp_valid), 0);
        chk("reset_iq_full", 32'(iq_full), 0);
        chk("reset_dsp_rd", 32'(dsp_rd), 0);
        chk("reset_dsp_op", 32'(dsp_op), 0);
        chk("reset_dsp_imm", dsp_imm, 0);
        chk("reset_dsp_pc", dsp_pc, 0);
        @(posedge clk);
        #1;
        rst = 0;
        run = 1;

        // ADDI x1,x0,5
        step(1, 32'h00500093);
        step(0, 0);
        step(0, 0);

        // fill the queue behind a full RS, then release it
        rs_full = 1;
        for (int i = 0; i < 5; i++) step(1, {12'(i), 5'd0, 3'b000, 5'(5 + i), 7'h13});
        rs_full = 0;
        repeat (6) step(0, 0);

        // ADD x3,x1,x2 then SUB x4,x3,x3
        rob_tail = 1;
        step(1, {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33});
        rob_tail = 2;
        step(1, {7'b0100000, 5'd3, 5'd3, 3'b000, 5'd4, 7'h33});
        rob_tail = 3;
        step(0, 0);
        rob_tail = 4;
        repeat (2) step(0, 0);

        // ADDI x7,x6,1 stalled with x6 renamed to tag 5, woken by the CDB
        rf_busy[6] = 1; rf_tag[6] = 5; rob_rdy[5] = 0;
        rs_full = 1;
        step(1, {12'd1, 5'd6, 3'b000, 5'd7, 7'h13});
        step(0, 0);
        cdb_valid = 1; cdb_tag = 5; cdb_val = 32'h1234; rs_full = 0;
        step(0, 0);
        cdb_valid = 0; rf_busy[6] = 0;
        step(0, 0);

        // flush with three entries queued
        rs_full = 1;
        repeat (3) step(1, {12'd3, 5'd1, 3'b000, 5'd2, 7'h13});
        flush = 1;
        step(0, 0);
        flush = 0; rs_full = 0;
        step(1, {12'd9, 5'd0, 3'b000, 5'd1, 7'h13});
        repeat (2) step(0, 0);

        // SW x2,8(x1) and BEQ x1,x2,-4
        step(1, {7'b0, 5'd2, 5'd1, 3'b010, 5'b01000, 7'h23});
        step(1, {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1110, 1'b1, 7'h63});
        repeat (2) step(0, 0);

        for (int n = 0; n < 2000; n++) begin
            rdy      = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            rob_full = ($urandom_range(0, 7) == 0);
            rs_full  = ($urandom_range(0, 5) == 0);
            lsb_full = ($urandom_range(0, 5) == 0);
            rob_tail = TW'($urandom);
            cdb_valid = 1'($urandom);
            cdb_tag   = TW'($urandom);
            cdb_val   = $urandom;
            begin
                int r;
                r = $urandom_range(1, 7);
                rf_busy[r] = 1'($urandom);
                rf_val[r]  = $urandom;
                rf_tag[r]  = TW'($urandom);
                r = $urandom_range(0, (1 << TW) - 1);
                rob_rdy[r]  = 1'($urandom);
                rob_vals[r] = $urandom;
            end
            step(($urandom_range(0, 2) != 0), gen_instr());
        end

        rdy = 1; flush = 0; rob_full = 0; rs_full = 0; lsb_full = 0; cdb_valid = 0;
        repeat (10) step(0, 0);
        #10;
        chk("scoreboard_drain", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
